spi_target: RTL and testbench

SPI responder (slave, mode 0: CPOL=0, CPHA=0, MSB first) that pairs with the block's SPI clock generator on the initiator side. The block receives external SCLK, CS_n and MOSI from an SPI initiator and oversamples them in the `clk_i` domain. It shifts complete words out on `rx_data_o` and presents host-supplied words on MISO. It sits between the SPI pins and the register or FIFO logic of an SPI-attached peripheral.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_target.sv | 190 +++++++++++++++++++
 tb/tb_spi_target.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM states, SPI mode and defaults.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Only SPI mode 0 is implemented.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  // IDLE_WORD defaults to this bit replicated across the word (all-ones).
  localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus edge register for one asynchronous pin.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (clears the edge pulses only)
//   din   : asynchronous pin
//   level : synchronised level
//   rise  : registered one-cycle pulse on a 0->1 transition
//   fall  : registered one-cycle pulse on a 1->0 transition
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] synchroniser, [2] edge history
  logic [2:0] sync_q;

  // The chain keeps tracking the pin during reset, so a pin already low when
  // reset releases does not produce a spurious edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], din};
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync_q[1] & ~sync_q[2];
      fall <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level = sync_q[1];

endmodule

// File: rtl/spi_target.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, oversampled in clk_i.
// Ports:
//   clk_i, rst_i         : system clock, synchronous active-high reset
//   sclk_i/cs_n_i/mosi_i : asynchronous SPI pins from the initiator
//   miso_o, miso_oe_o    : responder data and pad enable
//   tx_data_i/valid_i    : host TX write, accepted when tx_ready_o=1
//   tx_ready_o           : TX buffer empty
//   rx_data_o/valid_o    : last complete received word and update pulse
//   rx_abort_o           : CS released mid-word
//   tx_underrun_o        : a word started with the TX buffer empty
//   busy_o               : frame active
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned           FREQ_CLK   = 100000000,
  parameter int unsigned           FREQ_SPI   = 2000000,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = {DATA_WIDTH{DEFAULT_IDLE_BIT}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  rx_abort_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Elaboration guards: word length, oversampling ratio, SPI mode.
  if (DATA_WIDTH < 4) begin : g_bad_width
    $error("spi_target: DATA_WIDTH must be at least 4");
  end
  if (FREQ_CLK < 12 * FREQ_SPI) begin : g_bad_freq
    $error("spi_target: FREQ_CLK must be at least 12 * FREQ_SPI");
  end
  if (SPI_CPOL != 1'b0 || SPI_CPHA != 1'b0) begin : g_bad_mode
    $error("spi_target: only SPI mode 0 is supported");
  end

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_sclk (
    .clk(clk_i), .rst(rst_i), .din(sclk_i),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n_i rising means CS released, falling means CS asserted.
  spi_sync_edge u_sync_cs (
    .clk(clk_i), .rst(rst_i), .din(cs_n_i),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk(clk_i), .rst(rst_i), .din(mosi_i),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Levels of SCLK/CS and MOSI edges are not needed by the protocol logic.
  logic unused_sync;
  assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;   // first W-1 bits of a word
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;     // word being shifted out
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_empty_q, tx_empty_d;
  logic                  miso_q, miso_d;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_abort_q, rx_abort_d;
  logic                  tx_underrun_q, tx_underrun_d;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_word_q     <= '0;
      tx_buf_q      <= '0;
      tx_empty_q    <= 1'b1;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_abort_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_word_q     <= tx_word_d;
      tx_buf_q      <= tx_buf_d;
      tx_empty_q    <= tx_empty_d;
      miso_q        <= miso_d;
      busy_q        <= (state_d == ST_ACTIVE);
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_abort_q    <= rx_abort_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Next-state, shifting and host buffer logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_word_d     = tx_word_q;
    tx_buf_d      = tx_buf_q;
    tx_empty_d    = tx_empty_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_abort_d    = 1'b0;
    tx_underrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // CS release wins over any SCLK edge seen in the same cycle.
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_word_d  = '0;
          miso_d     = 1'b0;
          rx_abort_d = (bit_cnt_q != '0);
        end else begin
          // Keep the next word's MSB on the pin until its first rising edge.
          if (bit_cnt_q == '0)
            miso_d = tx_empty_q ? IDLE_WORD[DATA_WIDTH-1] : tx_buf_q[DATA_WIDTH-1];

          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
            if (bit_cnt_q == '0) begin
              tx_word_d     = tx_empty_q ? IDLE_WORD : tx_buf_q;
              tx_empty_d    = 1'b1;
              tx_underrun_d = tx_empty_q;
            end
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            miso_d = tx_word_q[LAST_BIT - bit_cnt_q];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host write after the pop, so a write landing on an underrun pop is kept.
    if (tx_valid_i && tx_empty_q) begin
      tx_buf_d   = tx_data_i;
      tx_empty_d = 1'b0;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = busy_q;
  assign busy_o        = busy_q;
  assign tx_ready_o    = tx_empty_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_abort_o    = rx_abort_q;
  assign tx_underrun_o = tx_underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a mode-0 SPI initiator model drives
// frames at SCLK = clk/50 and results are compared with expectations derived
// from the word-level protocol rules.
module tb_spi_target;

  localparam int H = 25;  // SCLK half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_abort, tx_underrun, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_target dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_abort_o(rx_abort),
    .tx_underrun_o(tx_underrun), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts output pulses and collects received words.
  int         n_valid = 0, n_abort = 0, n_under = 0, valid_cyc = 0;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_valid++;
        rx_q.push_back(rx_data);
        valid_cyc = cyc;
      end
      if (rx_abort) n_abort++;
      if (tx_underrun) n_under++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_miso"}, 32'(miso), 32'd0);
    check({p, "_miso_oe"}, 32'(miso_oe), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_rx_data"}, 32'(rx_data), 32'd0);
    check({p, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({p, "_rx_abort"}, 32'(rx_abort), 32'd0);
    check({p, "_underrun"}, 32'(tx_underrun), 32'd0);
    check({p, "_tx_ready"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic write_tx(input logic [7:0] d);
    int k = 0;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("tx_ready_before_write", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_write", 32'(tx_ready), 32'd0);
  endtask

  // Frame description shared by the initiator model and the checker.
  logic [7:0] mosi_w[4];
  logic [7:0] tx_w[4];
  bit         tx_wr[4];
  logic [7:0] miso_got[4];
  int         rise_cyc;
  logic       busy3, busy4, oe4;

  // Mode-0 initiator. Word i+1 is written by the host during bit 2 of word i.
  // abort_bits>0 releases CS after that many bits of the last word; race
  // releases CS together with the last word's final rising edge.
  task automatic frame(input int n, input int abort_bits, input bit race);
    cs_n = 1'b0;
    wait_cyc(3);
    busy3 = busy;
    wait_cyc(1);
    busy4 = busy;
    oe4   = miso_oe;
    wait_cyc(H - 4);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 8; b++) begin
        mosi = mosi_w[w][7-b];
        wait_cyc(H);
        if (race && w == n - 1 && b == 7) begin
          sclk = 1'b1;
          cs_n = 1'b1;
          wait_cyc(H);
          sclk = 1'b0;
          wait_cyc(H);
          return;
        end
        sclk = 1'b1;
        rise_cyc = cyc;
        miso_got[w][7-b] = miso;
        wait_cyc(H);
        sclk = 1'b0;
        if (b == 2 && w + 1 < n && tx_wr[w+1]) write_tx(tx_w[w+1]);
        if (w == n - 1 && abort_bits == b + 1) begin
          wait_cyc(H);
          cs_n = 1'b1;
          wait_cyc(H);
          return;
        end
      end
    end
    wait_cyc(H);
    cs_n = 1'b1;
    wait_cyc(H);
  endtask

  // Runs one frame and checks it against the word-level expectations.
  task automatic run_checked(input string tag, input int n, input int abort_bits, input bit race);
    int v0, a0, u0, comp, exp_under;
    logic [7:0] got;
    rx_q.delete();
    v0 = n_valid; a0 = n_abort; u0 = n_under;
    comp = (abort_bits > 0 || race) ? n - 1 : n;
    exp_under = 0;
    for (int i = 0; i < n; i++) if (!tx_wr[i]) exp_under++;
    if (tx_wr[0]) write_tx(tx_w[0]);
    frame(n, abort_bits, race);
    check({tag, "_valid_count"}, 32'(n_valid - v0), 32'(comp));
    check({tag, "_abort_count"}, 32'(n_abort - a0), 32'((abort_bits > 0 || race) ? 1 : 0));
    check({tag, "_underrun_count"}, 32'(n_under - u0), 32'(exp_under));
    for (int i = 0; i < comp; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check({tag, "_rx_word"}, 32'(got), 32'(mosi_w[i]));
      check({tag, "_miso_word"}, 32'(miso_got[i]), 32'(tx_wr[i] ? tx_w[i] : 8'hFF));
    end
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_oe_after"}, 32'(miso_oe), 32'd0);
    check({tag, "_tx_ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    wait_cyc(5);
    check_reset_vals("reset");
    rst = 1'b0;
    wait_cyc(5);

    // Basic word, with CS-to-busy and rising-edge-to-rx_valid latencies.
    mosi_w[0] = 8'h3C; tx_w[0] = 8'hA5; tx_wr[0] = 1'b1;
    run_checked("basic", 1, 0, 1'b0);
    check("basic_busy_at3", 32'(busy3), 32'd0);
    check("basic_busy_at4", 32'(busy4), 32'd1);
    check("basic_oe_at4", 32'(oe4), 32'd1);
    check("basic_valid_latency", 32'(valid_cyc - rise_cyc), 32'd4);
    check("basic_rx_data_held", 32'(rx_data), 32'h3C);

    // Back-to-back three-word frame.
    mosi_w[0] = 8'h01; mosi_w[1] = 8'h02; mosi_w[2] = 8'h03;
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    tx_wr[0] = 1'b1; tx_wr[1] = 1'b1; tx_wr[2] = 1'b1;
    run_checked("b2b", 3, 0, 1'b0);

    // Underrun: no host write.
    mosi_w[0] = 8'($urandom); tx_wr[0] = 1'b0;
    run_checked("underrun", 1, 0, 1'b0);

    // Abort after 5 bits, then a clean frame from bit 0.
    mosi_w[0] = 8'($urandom); tx_wr[0] = 1'b0;
    run_checked("abort", 1, 5, 1'b0);
    mosi_w[0] = 8'h5A; tx_wr[0] = 1'b0;
    run_checked("after_abort", 1, 0, 1'b0);

    // CS release racing the final rising edge.
    mosi_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); tx_wr[0] = 1'b1;
    run_checked("race", 1, 0, 1'b1);

    // Reset after 3 bits with a buffered host word pending.
    cs_n = 1'b0;
    wait_cyc(H);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'($urandom);
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
      if (b == 2) write_tx(8'($urandom));
    end
    wait_cyc(3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    cs_n = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(10);
    mosi_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); tx_wr[0] = 1'b1;
    run_checked("post_reset", 1, 0, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        mosi_w[i] = 8'($urandom);
        tx_w[i]   = 8'($urandom);
        tx_wr[i]  = 1'($urandom_range(0, 1));
      end
      run_checked("random", n, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
